// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
//   Shares one single-port on-chip RAM (1-cycle read latency) between two
//   Avalon-MM-style requesters. One transfer is granted per cycle; the current
//   owner keeps the port while it keeps requesting, but it yields after
//   HOLD_MAX consecutive grants if the other requester is waiting. Read
//   returns are tagged with the issuing requester. Addresses at or above
//   NUM_WORDS are accepted but never reach the RAM; they return zero data and
//   raise a one-cycle oor_err pulse.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   mN_address/byteenable/read/write/writedata   requester N command (N=0,1)
//   mN_waitrequest          0 = requester N accepted this cycle
//   mN_readdata/readdatavalid                    requester N read return
//   mem_*                   RAM slave port (mem_readdata is the RAM q)
//   oor_err                 registered pulse after an out-of-range accept
//
// States
//   IDLE | no grant last cycle; conflicts resolved by last_owner
//   OWN0 | m0 was granted last cycle
//   OWN1 | m1 was granted last cycle

module onchip_mem_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int NUM_WORDS = 30720,
  parameter int HOLD_MAX  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              oor_err
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int HOLD_LAST_I = HOLD_MAX - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_LAST_I[CNT_W-1:0];
  localparam logic [ADDR_W:0] WORDS_LIM = NUM_WORDS[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_owner_q, rd_owner_d;
  logic              rd_oor_q, rd_oor_d;
  logic              oor_err_q, oor_err_d;

  logic              req0, req1, hold_ok, same_owner;
  logic              gnt_valid, gnt_id, gnt_rd, gnt_wr, gnt_in_range;
  logic [ADDR_W-1:0] gnt_addr;
  logic [BE_W-1:0]   gnt_be;
  logic [DATA_W-1:0] gnt_wdata;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign hold_ok = hold_cnt_q < HOLD_LAST;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_oor_q     <= 1'b0;
      oor_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
      oor_err_q    <= oor_err_d;
    end
  end

  always_comb begin
    gnt_valid      = 1'b0;
    gnt_id         = 1'b0;
    state_d        = IDLE;
    last_owner_d   = last_owner_q;
    hold_cnt_d     = '0;
    rd_valid_d     = 1'b0;
    rd_owner_d     = 1'b0;
    rd_oor_d       = 1'b0;
    oor_err_d      = 1'b0;
    same_owner     = 1'b0;

    case (state_q)
      OWN0: begin
        if (req0 && (!req1 || hold_ok)) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end else if (req1) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
      end
      OWN1: begin
        if (req1 && (!req0 || hold_ok)) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end else if (req0) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          gnt_valid = 1'b1;
          gnt_id    = ~last_owner_q;
        end else if (req0) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end else if (req1) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
      end
    endcase

    // The registers are already held by the async reset, but the grant is
    // combinational and must also stay off while reset is asserted.
    if (!reset_n) gnt_valid = 1'b0;

    gnt_addr     = gnt_id ? m1_address    : m0_address;
    gnt_be       = gnt_id ? m1_byteenable : m0_byteenable;
    gnt_wdata    = gnt_id ? m1_writedata  : m0_writedata;
    gnt_rd       = gnt_id ? m1_read       : m0_read;
    gnt_wr       = gnt_id ? m1_write      : m0_write;
    gnt_in_range = {1'b0, gnt_addr} < WORDS_LIM;

    m0_waitrequest = ~(gnt_valid & ~gnt_id);
    m1_waitrequest = ~(gnt_valid & gnt_id);
    mem_clken      = gnt_valid;
    mem_chipselect = gnt_valid & gnt_in_range;
    mem_write      = gnt_valid & gnt_in_range & gnt_wr;
    mem_address    = gnt_valid ? gnt_addr  : '0;
    mem_byteenable = gnt_valid ? gnt_be    : '0;
    mem_writedata  = gnt_valid ? gnt_wdata : '0;

    if (gnt_valid) begin
      same_owner   = ((state_q == OWN0) && !gnt_id) || ((state_q == OWN1) && gnt_id);
      state_d      = gnt_id ? OWN1 : OWN0;
      last_owner_d = gnt_id;
      if (same_owner)
        hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + 1'b1;
      // A write that also asserts read wins, so it produces no read return.
      rd_valid_d   = gnt_rd & ~gnt_wr;
      rd_owner_d   = gnt_id;
      rd_oor_d     = ~gnt_in_range;
      oor_err_d    = ~gnt_in_range;
    end
  end

  // RAM q is stale for out-of-range reads, so the return is forced to zero.
  assign m0_readdata      = rd_oor_q ? '0 : mem_readdata;
  assign m1_readdata      = rd_oor_q ? '0 : mem_readdata;
  assign m0_readdatavalid = rd_valid_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_valid_q & rd_owner_q;
  assign oor_err          = oor_err_q;

endmodule
